spart_rx: RTL and testbench

Receive stage of the SPART. Consumes the 16x-oversample `enable` tick produced by the baud-rate generator and deserialises the asynchronous `rxd` line (8N1, LSB first) into a parallel byte. Presents the byte with a receive-data-available flag and error flags to the bus interface, which acknowledges with a one-cycle read strobe.

---
 rtl/spart_rx.sv | 196 +++++++++++++++++++
 tb/tb_spart_rx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_rx.sv
// -----------------------------------------------------------------------------
// spart_rx
//
// Receive stage of the SPART. Uses the oversampled baud tick from the baud-rate
// generator to find the start bit of an asynchronous 8N1 (LSB first) frame on
// rxd. It samples each data bit at mid-bit and presents the assembled byte to
// the bus interface, together with a data-available flag and error flags.
//
// Parameters
//   DATA_BITS   data bits per frame (5..8)
//   OVERSAMPLE  enable ticks per bit period (even, >= 4)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       one-clk-wide baud tick (OVERSAMPLE ticks per bit)
//   rxd          serial receive line, idles high
//   rd           one-clk-wide read strobe, acknowledges the held byte
//   rx_data      last received byte
//   rda          receive data available
//   framing_err  stop bit of the held byte was sampled low
//   overrun_err  a byte completed while rda was still set
//
// Build option
//   SPART_RX_SYNC_EN  when defined, rxd passes through a two-flop synchroniser
//                     (flops reset to 1) before the FSM, which adds two clk of
//                     latency to every sample. When undefined, rxd is sampled
//                     directly. Use the undefined build only when rxd is
//                     already synchronous to clk.
// -----------------------------------------------------------------------------
module spart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 rxd,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 framing_err,
    output logic                 overrun_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [TW-1:0]        tick_cnt;
    logic [TW-1:0]        tick_next;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_next;
    logic [DATA_BITS-1:0] shift;
    logic                 shift_en;
    logic                 complete;
    logic                 rxd_s;

`ifdef SPART_RX_SYNC_EN
    logic sync_1;
    logic sync_2;

    // Two-flop synchroniser for the asynchronous line. Both flops reset to the
    // idle level so that a reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= rxd;
            sync_2 <= sync_1;
        end
    end

    assign rxd_s = sync_2;
`else
    assign rxd_s = rxd;
`endif

    // State, tick counter and bit counter registers. All the decisions are
    // made in the combinational block below. Here the values are only captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            bit_cnt  <= bit_next;
        end
    end

    // Next-state logic. Nothing moves without a baud tick. START waits half a
    // bit so that every later sample lands at mid-bit. DATA and STOP then step
    // one full bit at a time. STOP returns to IDLE at mid-stop, so the next
    // start bit can follow straight after the stop bit.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_en   = 1'b0;
        complete   = 1'b0;
        if (enable) begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        tick_next  = '0;
                        bit_next   = '0;
                        state_next = START;
                    end
                end
                START: begin
                    if (tick_cnt == MID_TICK) begin
                        tick_next  = '0;
                        state_next = rxd_s ? IDLE : DATA;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_next = '0;
                        shift_en  = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_next   = '0;
                            state_next = STOP;
                        end else begin
                            bit_next = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_next  = '0;
                        complete   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Shift register. Bits arrive LSB first, so each new bit enters at the
    // top. After DATA_BITS shifts, the first bit received sits in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
        end else if (shift_en) begin
            shift <= {rxd_s, shift[DATA_BITS-1:1]};
        end
    end

    // Bus-facing holding register and flags. When a frame completes on the
    // same edge as a read strobe, the new frame wins. In that case rda stays
    // set and no overrun is reported, because the old byte was just read.
    // A read clears the flags only. rx_data keeps its value so that software
    // can still look at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else if (complete) begin
            rx_data     <= shift;
            rda         <= 1'b1;
            framing_err <= ~rxd_s;
            overrun_err <= rda & ~rd;
        end else if (rd) begin
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// -----------------------------------------------------------------------------
// tb_spart_rx
//
// Drives 8N1 frames into spart_rx from a bench-side baud tick. The tick is one
// clk in four by default, or every clk when tie_high is set. A frame-level
// model predicts the edge on which each byte must complete, using the
// start-bit edge and the nominal frame length. From that it keeps the expected
// state of rx_data and the flags. The expected state is compared with the DUT
// on every falling clock edge while out of reset. Hand-computed literals
// check the main results and pin the model.
// -----------------------------------------------------------------------------
module tb_spart_rx;

    localparam int OS = 16;
    localparam int DB = 8;
`ifdef SPART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b0;
    logic       rxd    = 1'b1;
    logic       rd     = 1'b0;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       overrun_err;

    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    bit   tie_high   = 1'b0;
    bit   cmp_on     = 1'b1;

    int         comp_cycle = 0;
    int         start_edge = 0;
    logic [7:0] m_data     = 8'h00;
    logic       m_stop     = 1'b1;

    logic [7:0] exp_data = 8'h00;
    logic       exp_rda  = 1'b0;
    logic       exp_fe   = 1'b0;
    logic       exp_oe   = 1'b0;

    logic       rda_q    = 1'b0;
    int         rise_cyc = 0;

    spart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rxd         (rxd),
        .rd          (rd),
        .rx_data     (rx_data),
        .rda         (rda),
        .framing_err (framing_err),
        .overrun_err (overrun_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // cyc holds the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // The baud tick is set up on the falling edge for the next rising edge.
    // Edge n is a tick when n is a multiple of four, or on every edge when
    // tie_high is set.
    always @(negedge clk) enable <= tie_high ? 1'b1 : (((cyc + 1) % 4) == 0);

    // Frame-level model. A byte completes on edge comp_cycle. Otherwise a read
    // strobe clears the flags. Reset clears everything.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_data <= 8'h00;
            exp_rda  <= 1'b0;
            exp_fe   <= 1'b0;
            exp_oe   <= 1'b0;
        end else if (comp_cycle != 0 && cyc + 1 == comp_cycle) begin
            exp_data <= m_data;
            exp_rda  <= 1'b1;
            exp_fe   <= ~m_stop;
            exp_oe   <= exp_rda & ~rd;
        end else if (rd) begin
            exp_rda <= 1'b0;
            exp_fe  <= 1'b0;
            exp_oe  <= 1'b0;
        end
    end

    // Records the edge on which rda last rose, for the latency checks.
    always @(negedge clk) begin
        rda_q <= rda;
        if (rda && !rda_q) rise_cyc <= cyc;
    end

    // Compare the DUT with the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && cmp_on) begin
            checks = checks + 1;
            if ({rx_data, rda, framing_err, overrun_err} !== {exp_data, exp_rda, exp_fe, exp_oe}) begin
                errors = errors + 1;
                $display("[TB] FAIL model_cmp cyc=%0d got data=%h rda=%b fe=%b oe=%b expected data=%h rda=%b fe=%b oe=%b",
                         cyc, rx_data, rda, framing_err, overrun_err, exp_data, exp_rda, exp_fe, exp_oe);
            end
        end
    end

    // Single literal comparison against a hand-computed value.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual != expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Waits for n tick edges, then returns on the next falling edge.
    task automatic waitTicks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!enable) @(posedge clk);
        end
        @(negedge clk);
    endtask

    // Holds the line idle for a number of bit periods.
    task automatic idleBits(input int n);
        rxd = 1'b1;
        waitTicks(n * OS);
    endtask

    // One-clk read strobe. Returns on the falling edge after the edge that
    // sampled the strobe.
    task automatic pulseRd();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    // Sends one frame. The caller must have just returned from waitTicks, so
    // the last edge was a tick edge. The model is told which edge the stop
    // sample must land on. That edge is the first tick at which the start bit
    // is visible past the synchroniser, plus half a bit, plus DB+1 full bits.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        int p;
        p          = tie_high ? 1 : 4;
        start_edge = cyc;
        m_data     = data;
        m_stop     = stop_bit;
        comp_cycle = cyc + p * ((1 + SYNC_LAT + p - 1) / p) + p * (OS / 2 + (DB + 1) * OS);
        rxd = 1'b0;
        waitTicks(OS);
        for (int i = 0; i < DB; i++) begin
            rxd = data[i];
            waitTicks(OS);
        end
        rxd = stop_bit;
        waitTicks(OS);
        rxd = 1'b1;
    endtask

    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : main
        int guard;

        // Reset.
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_data", rx_data, 8'h00);
        checkOutput("reset_rda", rda, 0);
        checkOutput("reset_fe", framing_err, 0);
        checkOutput("reset_oe", overrun_err, 0);

        // Basic frame 0xA5, then read it.
        waitTicks(1);
        idleBits(1);
        applyStimulus(8'hA5, 1'b1);
        checkOutput("a5_data", rx_data, 8'hA5);
        checkOutput("a5_rda", rda, 1);
        checkOutput("a5_fe", framing_err, 0);
        checkOutput("a5_oe", overrun_err, 0);
        checkOutput("a5_latency", rise_cyc - start_edge, 612);
        pulseRd();
        checkOutput("a5_rd_rda", rda, 0);
        checkOutput("a5_rd_data", rx_data, 8'hA5);

        // False start: four low ticks, then high.
        idleBits(1);
        comp_cycle = 0;
        rxd = 1'b0;
        waitTicks(4);
        rxd = 1'b1;
        waitTicks(2 * OS);
        checkOutput("false_start_rda", rda, 0);
        applyStimulus(8'h3C, 1'b1);
        checkOutput("after_false_data", rx_data, 8'h3C);
        checkOutput("after_false_rda", rda, 1);
        pulseRd();

        // Framing error, then read clears the flags.
        idleBits(1);
        applyStimulus(8'h3C, 1'b0);
        checkOutput("fe_data", rx_data, 8'h3C);
        checkOutput("fe_rda", rda, 1);
        checkOutput("fe_flag", framing_err, 1);
        idleBits(1);
        pulseRd();
        checkOutput("fe_rd_rda", rda, 0);
        checkOutput("fe_rd_fe", framing_err, 0);
        checkOutput("fe_rd_oe", overrun_err, 0);

        // Back-to-back frames without a read: overrun.
        waitTicks(1);
        idleBits(1);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        checkOutput("ovr_data", rx_data, 8'h22);
        checkOutput("ovr_rda", rda, 1);
        checkOutput("ovr_flag", overrun_err, 1);
        pulseRd();

        // Back-to-back again, with rd on the second byte's completion edge.
        waitTicks(1);
        idleBits(1);
        applyStimulus(8'h11, 1'b1);
        fork
            applyStimulus(8'h22, 1'b1);
            begin
                @(negedge clk);
                guard = 0;
                while (cyc != comp_cycle - 1 && guard < 4000) begin
                    @(negedge clk);
                    guard++;
                end
                checkOutput("rd_align_timeout", guard < 4000, 1);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        checkOutput("rd_same_edge_data", rx_data, 8'h22);
        checkOutput("rd_same_edge_rda", rda, 1);
        checkOutput("rd_same_edge_oe", overrun_err, 0);

        // Reset during data bit 3 of 0xFF, with rda still set.
        idleBits(1);
        comp_cycle = 0;
        rxd = 1'b0;
        waitTicks(OS);
        for (int i = 0; i < 3; i++) begin
            rxd = 1'b1;
            waitTicks(OS);
        end
        rxd = 1'b1;
        waitTicks(OS / 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_data", rx_data, 8'h00);
        checkOutput("midrst_rda", rda, 0);
        checkOutput("midrst_fe", framing_err, 0);
        checkOutput("midrst_oe", overrun_err, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        waitTicks(1);
        idleBits(1);
        applyStimulus(8'h5A, 1'b1);
        checkOutput("post_rst_data", rx_data, 8'h5A);
        checkOutput("post_rst_rda", rda, 1);
        checkOutput("post_rst_fe", framing_err, 0);
        checkOutput("post_rst_oe", overrun_err, 0);
        pulseRd();

        // enable tied high: one tick per clk.
        tie_high = 1'b1;
        waitTicks(2);
        idleBits(1);
        applyStimulus(8'h81, 1'b1);
        checkOutput("tie_data", rx_data, 8'h81);
        checkOutput("tie_rda", rda, 1);
        checkOutput("tie_latency", rise_cyc - start_edge, 153 + SYNC_LAT);

        waitTicks(4);
        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
